// File: rtl/mbist_pkg.sv
// Purpose: shared types and March C- tables for the MBIST march controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, 3-bit element codes M0..M5, the {is_write,
// data_bit} operation type, the per-element operation count table and the
// helpers that decode an (element, phase) pair into an operation.
package mbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        M0 = 3'd0,   // up   (w0)
        M1 = 3'd1,   // up   (r0, w1)
        M2 = 3'd2,   // up   (r1, w0)
        M3 = 3'd3,   // down (r0, w1)
        M4 = 3'd4,   // down (r1, w0)
        M5 = 3'd5    // down (r0)
    } elem_t;

    typedef struct packed {
        logic is_write;
        logic data_bit;   // background bit written, or expected on a read
    } op_t;

    localparam int unsigned NUM_ELEMS = 6;

    // Operations per address for each element, indexed by elem_t.
    localparam logic [NUM_ELEMS-1:0][1:0] ELEM_OPS = {
        2'd1,   // M5
        2'd2,   // M4
        2'd2,   // M3
        2'd2,   // M2
        2'd2,   // M1
        2'd1    // M0
    };

    function automatic logic elem_is_down(input elem_t e);
        return (e >= M3);
    endfunction

    // Phase 0 is the first operation of the element at an address, phase 1
    // the second (only two-operation elements ever reach phase 1).
    function automatic op_t elem_op(input elem_t e, input logic phase);
        op_t op;
        case (e)
            M0:      op = '{is_write: 1'b1, data_bit: 1'b0};
            M1, M3:  op = phase ? op_t'{is_write: 1'b1, data_bit: 1'b1}
                                : op_t'{is_write: 1'b0, data_bit: 1'b0};
            M2, M4:  op = phase ? op_t'{is_write: 1'b1, data_bit: 1'b0}
                                : op_t'{is_write: 1'b0, data_bit: 1'b1};
            default: op = '{is_write: 1'b0, data_bit: 1'b0};
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Purpose: loadable up/down address counter for the march sequencer.
// Latency: address updates on the clock edge after load/step.
// Backpressure: none; the sequencer steps it at most once per cycle.
//
// Ports: clk/rst (async active-high); load reloads the element start address
// (last address when load_down, else 0); step moves one address in the
// direction given by down; last flags the final address of the current sweep.
module mbist_addr_gen #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    input  logic                  down,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_down ? '1 : '0;
        end else if (step) begin
            addr <= down ? (addr - ADDR_WIDTH'(1)) : (addr + ADDR_WIDTH'(1));
        end
    end

    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// Purpose: March C- memory BIST controller with sticky fail flag.
// Latency: done pulses 10*2**ADDR_WIDTH+READ_LAT+1 cycles after start.
// Backpressure: none; one memory op per cycle, start ignored while busy/done.
//
// Ports: start (1-cycle request), busy, done (1-cycle pulse), fail (sticky);
// memory side mem_write_read (1=write), mem_address, mem_wdata (one cycle
// ahead of the write it belongs to), mem_rdata (valid READ_LAT after issue).
// Optional MBIST_DIAG_EN adds fail_addr/fail_elem/fail_syndrome, captured on
// the first miscompare of a run.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int READ_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MBIST_DIAG_EN
    ,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_syndrome
`endif
);

    localparam int DCW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t                state, state_nxt;
    elem_t                 elem, elem_nxt;
    logic                  phase, phase_nxt;
    logic [DCW-1:0]        drain_cnt;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_last;
    logic                  addr_down;
    logic                  ag_load;
    logic                  ag_load_down;
    logic                  ag_step;

    op_t                   cur_op;
    op_t                   nxt_op;
    logic                  in_run;
    logic                  elem_last_op;
    logic                  start_acc;

    // Expected-data delay line: one entry per cycle, valid only for reads.
    logic [READ_LAT-1:0]                 dl_vld;
    logic [READ_LAT-1:0][DATA_WIDTH-1:0] dl_exp;
    logic                                miscompare;

    assign in_run       = (state == ST_RUN);
    assign start_acc    = (state == ST_IDLE) && start;
    assign cur_op       = elem_op(elem, phase);
    assign elem_last_op = ({1'b0, phase} == (ELEM_OPS[elem] - 2'd1));
    assign addr_down    = elem_is_down(elem);

    mbist_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (addr_down),
        .addr      (addr),
        .last      (addr_last)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            elem  <= M0;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            elem  <= elem_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        elem_nxt     = elem;
        phase_nxt    = phase;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    elem_nxt  = M0;
                    phase_nxt = 1'b0;
                    ag_load   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!elem_last_op) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (!addr_last) begin
                        ag_step = 1'b1;
                    end else if (elem == M5) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        // Next element starts straight away at its own first
                        // address, so no bubble between elements.
                        elem_nxt     = elem_t'(elem + 3'd1);
                        ag_load      = 1'b1;
                        ag_load_down = elem_is_down(elem_nxt);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DCW'(READ_LAT - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Waits out the read latency so the final M5 reads are still checked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt + DCW'(1);
        end else begin
            drain_cnt <= '0;
        end
    end

    // --------------------------------------------------------- memory bus
    assign mem_write_read = in_run && cur_op.is_write;
    assign mem_address    = in_run ? addr : '0;

    // The memory samples write data a cycle before the write strobe, so the
    // bus carries the data of the operation the FSM is about to issue.
    assign nxt_op    = elem_op(elem_nxt, phase_nxt);
    assign mem_wdata = ((state_nxt == ST_RUN) && nxt_op.is_write) ?
                       {DATA_WIDTH{nxt_op.data_bit}} : '0;

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

    // ------------------------------------------------------------ compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_vld <= '0;
            dl_exp <= '0;
        end else begin
            dl_vld[0] <= in_run && !cur_op.is_write;
            dl_exp[0] <= {DATA_WIDTH{cur_op.data_bit}};
            for (int i = 1; i < READ_LAT; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_exp[i] <= dl_exp[i-1];
            end
        end
    end

    assign miscompare = dl_vld[READ_LAT-1] && (mem_rdata != dl_exp[READ_LAT-1]);

    // A miscompare only flags the run; the march always completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail <= 1'b0;
        end else if (start_acc) begin
            fail <= 1'b0;
        end else if (miscompare) begin
            fail <= 1'b1;
        end
    end

`ifdef MBIST_DIAG_EN
    logic [READ_LAT-1:0][ADDR_WIDTH-1:0] dl_addr;
    logic [READ_LAT-1:0][2:0]            dl_elem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_addr <= '0;
            dl_elem <= '0;
        end else begin
            dl_addr[0] <= addr;
            dl_elem[0] <= elem;
            for (int i = 1; i < READ_LAT; i++) begin
                dl_addr[i] <= dl_addr[i-1];
                dl_elem[i] <= dl_elem[i-1];
            end
        end
    end

    // fail still low means this is the first miscompare of the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_addr     <= '0;
            fail_elem     <= '0;
            fail_syndrome <= '0;
        end else if (start_acc) begin
            fail_addr     <= '0;
            fail_elem     <= '0;
            fail_syndrome <= '0;
        end else if (miscompare && !fail) begin
            fail_addr     <= dl_addr[READ_LAT-1];
            fail_elem     <= dl_elem[READ_LAT-1];
            fail_syndrome <= dl_exp[READ_LAT-1] ^ mem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_mbist_march_ctrl.sv
module tb_mbist_march_ctrl;

    localparam int DW       = 8;
    localparam int AW       = 4;
    localparam int RL       = 2;
    localparam int NADDR    = 1 << AW;
    localparam int NOPS     = 10 * NADDR;     // 160
    localparam int DONE_CYC = NOPS + RL + 1;  // 163
    localparam logic [DW-1:0] ZERO = '0;
    localparam logic [DW-1:0] ONES = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          fail;
    logic          mem_write_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef MBIST_DIAG_EN
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [DW-1:0] fail_syndrome;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mbist_march_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .READ_LAT   (RL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .fail           (fail),
        .mem_write_read (mem_write_read),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
`ifdef MBIST_DIAG_EN
        ,
        .fail_addr      (fail_addr),
        .fail_elem      (fail_elem),
        .fail_syndrome  (fail_syndrome)
`endif
    );

    // Memory model: write data captured one cycle ahead of the write strobe,
    // read data returned RL cycles after the read. Optional bit-0 stuck-at-0
    // at address 5.
    logic [DW-1:0] mem [NADDR];
    logic [DW-1:0] wq;
    logic [DW-1:0] rpipe [RL];
    logic [DW-1:0] rd_val;
    bit            fault_en = 1'b0;

    always_comb begin
        rd_val = mem[mem_address];
        if (fault_en && mem_address == AW'(5)) rd_val[0] = 1'b0;
    end

    always @(posedge clk) begin
        wq <= mem_wdata;
        if (mem_write_read) mem[mem_address] <= wq;
        rpipe[0] <= rd_val;
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end

    assign mem_rdata = rpipe[RL-1];

    // Scoreboard of expected bus operations.
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } bus_op_t;

    bus_op_t exp_q[$];

    task automatic push_op(input logic wr, input int a, input logic [DW-1:0] d);
        bus_op_t op;
        op.wr   = wr;
        op.addr = AW'(a);
        op.data = d;
        exp_q.push_back(op);
    endtask

    task automatic push_march();
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < NADDR; k++) begin
                int a;
                a = (e >= 3) ? (NADDR - 1 - k) : k;
                case (e)
                    0:       push_op(1'b1, a, ZERO);
                    1, 3:    begin push_op(1'b0, a, ZERO); push_op(1'b1, a, ONES); end
                    2, 4:    begin push_op(1'b0, a, ONES); push_op(1'b1, a, ZERO); end
                    default: push_op(1'b0, a, ZERO);
                endcase
            end
        end
    endtask

    // One march from a start pulse. rst_at>0 asserts reset at that RUN cycle;
    // restart_at / restart_in_done pulse start again where they must be ignored.
    task automatic run_pass(input bit flt, input int rst_at, input int restart_at,
                            input bit restart_in_done, input bit exp_fail);
        bus_op_t       op;
        logic [DW-1:0] prev_wd;
        logic          exp_busy;
        fault_en = flt;
        push_march();
        @(negedge clk);
        start   = 1'b1;
        prev_wd = ZERO;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= DONE_CYC + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == restart_at || (restart_in_done && c == DONE_CYC)) start = 1'b1;
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                n_chk++;
                if ({busy, done, fail, mem_write_read} !== 4'b0000 || mem_address !== '0 ||
                    mem_wdata !== '0) begin
                    n_fail++;
                    $display("FAIL rst_mid_outputs: busy=%b done=%b fail=%b wr=%b addr=%h wdata=%h, want all 0",
                             busy, done, fail, mem_write_read, mem_address, mem_wdata);
                end
                repeat (2) @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    n_chk++;
                    if (mem_write_read !== 1'b0 || busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rst_mid_quiet: cycle %0d wr=%b busy=%b, want 0 0", k, mem_write_read, busy);
                    end
                end
                exp_q.delete();
                return;
            end
            if (c == 1) begin
                n_chk++;
                if (fail !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fail_clear_on_start: fail=%b want 0", fail);
                end
            end
            exp_busy = (c <= NOPS + RL);
            n_chk++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy c=%0d: got %b want %b", c, busy, exp_busy);
            end
            n_chk++;
            if (done !== (c == DONE_CYC)) begin
                n_fail++;
                $display("FAIL done c=%0d: got %b want %b", c, done, (c == DONE_CYC));
            end
            if (c <= NOPS) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL op_underflow c=%0d: scoreboard empty", c);
                end else begin
                    op = exp_q.pop_front();
                    n_chk++;
                    if (mem_write_read !== op.wr || mem_address !== op.addr) begin
                        n_fail++;
                        $display("FAIL op c=%0d: got wr=%b addr=%0d want wr=%b addr=%0d",
                                 c, mem_write_read, mem_address, op.wr, op.addr);
                    end
                    if (op.wr) begin
                        n_chk++;
                        if (prev_wd !== op.data) begin
                            n_fail++;
                            $display("FAIL wdata c=%0d: early data %h want %h", c, prev_wd, op.data);
                        end
                    end
                end
            end else begin
                n_chk++;
                if (mem_write_read !== 1'b0 || mem_address !== '0) begin
                    n_fail++;
                    $display("FAIL idle_bus c=%0d: wr=%b addr=%0d want 0 0", c, mem_write_read, mem_address);
                end
            end
            prev_wd = mem_wdata;
            if (c == DONE_CYC) begin
                n_chk++;
                if (fail !== exp_fail) begin
                    n_fail++;
                    $display("FAIL fail_at_done: got %b want %b", fail, exp_fail);
                end
`ifdef MBIST_DIAG_EN
                n_chk++;
                if (fail_addr !== (exp_fail ? AW'(5) : AW'(0)) ||
                    fail_elem !== (exp_fail ? 3'd2 : 3'd0) ||
                    fail_syndrome !== (exp_fail ? 8'h01 : 8'h00)) begin
                    n_fail++;
                    $display("FAIL diag: addr=%0d elem=%0d syn=%h, exp_fail=%b",
                             fail_addr, fail_elem, fail_syndrome, exp_fail);
                end
`endif
            end
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL op_count: %0d ops never issued, want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_chk++;
        if (fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b want 0", fail); end
        n_chk++;
        if (mem_write_read !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", mem_write_read); end
        n_chk++;
        if (mem_address !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", mem_address); end
        n_chk++;
        if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b want 0", busy); end
    endtask

    task automatic test_clean_trace();
        run_pass(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_fault();
        run_pass(1'b1, 0, 0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        n_chk++;
        if (fail !== 1'b1) begin n_fail++; $display("FAIL fail_sticky: got %b want 1", fail); end
    endtask

    task automatic test_fail_clear();
        run_pass(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_pass(1'b0, 40, 0, 1'b0, 1'b0);
        run_pass(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_pass(1'b0, 0, 50, 1'b1, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        test_reset();
        test_clean_trace();
        test_fault();
        test_fail_clear();
        test_reset_mid();
        test_ignore_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the memory word width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 4, meaning the memory address width; the last address is 2**ADDR_WIDTH-1.
REQ-003 The module SHALL have parameter READ_LAT, default 2, meaning the cycles from read issue to valid mem_rdata.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 The module SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit, a one-cycle test request.
REQ-007 The module SHALL have port busy, output, 1 bit, high while a test runs.
REQ-008 The module SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-009 The module SHALL have port fail, output, 1 bit, a sticky miscompare flag.
REQ-010 The module SHALL have port mem_write_read, output, 1 bit: 1 = write, 0 = read.
REQ-011 The module SHALL have port mem_address, output, ADDR_WIDTH bits, the memory address.
REQ-012 The module SHALL have port mem_wdata, output, DATA_WIDTH bits, the memory write data.
REQ-013 The module SHALL have port mem_rdata, input, DATA_WIDTH bits, the memory read data.

Function
REQ-014 The module SHALL run March C- with all-zero/all-one background: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 down(r0). This is 10*2**ADDR_WIDTH operations.
REQ-015 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE, with these transitions:
- IDLE->RUN on start;
- RUN->DRAIN after the last M5 read at address 0;
- DRAIN->DONE after READ_LAT cycles;
- DONE->IDLE unconditionally.
REQ-016 In RUN, the module SHALL issue exactly one operation per cycle, with no idle cycles between elements.
REQ-017 Address ordering: up elements SHALL run 0 to last, and down elements SHALL run last to 0. The address counter SHALL wrap between elements without issuing an extra operation.
REQ-018 The memory registers write data one cycle early, so mem_wdata in cycle t SHALL carry the write data of the operation issued in cycle t+1.
REQ-019 Each read SHALL push its expected word into a READ_LAT-deep delay line. mem_rdata SHALL be compared READ_LAT cycles after issue, and any mismatch SHALL set fail.
REQ-020 Outside RUN, mem_write_read SHALL be 0 and mem_address SHALL be 0.
REQ-021 busy SHALL be high in RUN and DRAIN only.
REQ-022 done SHALL pulse exactly 10*2**ADDR_WIDTH+READ_LAT+1 cycles after start is sampled.
REQ-023 start SHALL be ignored while busy is high or done is high.
REQ-024 fail SHALL clear when a new start is accepted, and SHALL otherwise hold until the next start or reset.
REQ-025 A miscompare SHALL NOT stop the test; the test always runs to completion.

Reset
REQ-026 On rst, all of the following SHALL clear immediately, including mid-test, with no memory write issued afterward: busy, done, fail, mem_write_read, mem_address, mem_wdata, the delay line, and the FSM (to IDLE).

Configuration
REQ-027 With MBIST_DIAG_EN defined, the module SHALL add these outputs, captured on the first miscompare only and cleared by start or reset:
- fail_addr (ADDR_WIDTH bits);
- fail_elem (3 bits);
- fail_syndrome (DATA_WIDTH bits, expected XOR actual).
REQ-028 Without MBIST_DIAG_EN, those ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package mbist_pkg SHALL hold the FSM state enum, the 3-bit element codes M0..M5, the operation typedef {is_write, data_bit}, and the per-element operation count table.
REQ-030 Sub-module mbist_addr_gen SHALL implement the loadable up/down address counter with a last-address flag.

Verification
REQ-031 Fault-free memory, ADDR_WIDTH=4, start pulse -> busy for 162 cycles, done pulses at cycle 163, fail=0.
REQ-032 Bit 0 of address 5 stuck-at-0 -> fail=1 at done; with MBIST_DIAG_EN, fail_addr=5, fail_elem=M2 (first r1), fail_syndrome=8'h01.
REQ-033 Fault-free run, trace the bus -> 160 operations in the exact March C- order, and the M3 addresses run 15 down to 0.
REQ-034 Assert rst at cycle 40 of RUN -> all outputs 0 in the same cycle; a later start completes a clean pass.
REQ-035 start pulsed again at cycle 50 of RUN and again during DONE -> both ignored; a single done pulse, timing unchanged.
REQ-036 A failing run followed by start on a fault-free memory -> fail clears on acceptance and reads 0 at the second done.
